// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package regfile_pkg;
  localparam int WIDTH   = 32;
  localparam int ADDR    = 5;
  localparam int STAMP_W = 4;

  // One queued writeback: destination, value and its global age stamp.
  typedef struct packed {
    logic [ADDR-1:0]    addr;
    logic [WIDTH-1:0]   data;
    logic [STAMP_W-1:0] stamp;
  } wb_entry_t;

  // Modular age compare: x is older than y when (x - y) wraps negative.
  function automatic logic stamp_older(input logic [STAMP_W-1:0] x,
                                       input logic [STAMP_W-1:0] y);
    logic [STAMP_W-1:0] diff;
    diff = x - y;
    return diff[STAMP_W-1];
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small circular writeback FIFO; also exposes every slot's valid/addr so the
// parent can build the pending-write mask without draining the queue.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        Clk,
  input  logic                        ResetN,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic                        empty,
  output logic                        full,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][ADDR-1:0]  ent_addr
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;   // a full FIFO never accepts, even while popping
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[head_q];

  // Next-state for pointers, occupancy and the storage array.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[tail_q] = push_entry;
      tail_d        = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end
    if (pop_ok) begin
      head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    end
  end

  // Control state: pointers and count, cleared by reset.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are meaningless until covered by count.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  // A slot is live when its distance from head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [CNT_W-1:0] offset;
    always_comb begin
      if (PTR_W'(gi) >= head_q) offset = CNT_W'(gi) - CNT_W'(head_q);
      else                      offset = CNT_W'(gi) + CNT_W'(DEPTH) - CNT_W'(head_q);
    end
    assign ent_valid[gi] = (offset < count_q);
    assign ent_addr[gi]  = mem_q[gi].addr;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port:
// per-requester FIFOs, age stamps, round-robin / oldest-first arbitration,
// registered write stage and a pending-write mask for the issue stage.
module regfile_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             A_Valid,
  output logic             A_Ready,
  input  logic [ADDR-1:0]  A_Addr,
  input  logic [WIDTH-1:0] A_Data,
  input  logic             B_Valid,
  output logic             B_Ready,
  input  logic [ADDR-1:0]  B_Addr,
  input  logic [WIDTH-1:0] B_Data,
  output logic             RegWrite,
  output logic [ADDR-1:0]  WriteRegister,
  output logic [WIDTH-1:0] WriteData,
  output logic [31:0]      PendingMask,
  output logic             GrantB
);
  import regfile_pkg::*;

  wb_entry_t                  a_head, b_head, a_push_entry, b_push_entry;
  logic                       a_empty, a_full, b_empty, b_full;
  logic                       a_push, b_push, grant_a, grant_b;
  logic [DEPTH-1:0]           a_ent_valid, b_ent_valid;
  logic [DEPTH-1:0][ADDR-1:0] a_ent_addr, b_ent_addr;

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               last_b_q, last_b_d;
  logic               reg_write_q, reg_write_d;
  logic [ADDR-1:0]    write_register_q, write_register_d;
  logic [WIDTH-1:0]   write_data_q, write_data_d;
  logic               grant_b_q, grant_b_d;
  logic [31:0]        mask;

  // Register 0 writes complete the handshake but are dropped here.
  assign A_Ready = !a_full;
  assign B_Ready = !b_full;
  assign a_push  = A_Valid && !a_full && (A_Addr != '0);
  assign b_push  = B_Valid && !b_full && (B_Addr != '0);

  // Stamp new entries; a same-cycle pair gives A the older stamp.
  always_comb begin
    a_push_entry.addr  = A_Addr;
    a_push_entry.data  = A_Data;
    a_push_entry.stamp = stamp_q;
    b_push_entry.addr  = B_Addr;
    b_push_entry.data  = B_Data;
    b_push_entry.stamp = stamp_q + STAMP_W'(a_push);
    stamp_d            = stamp_q + STAMP_W'(a_push) + STAMP_W'(b_push);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .Clk(Clk), .ResetN(ResetN), .push(a_push), .push_entry(a_push_entry),
    .pop(grant_a), .head(a_head), .empty(a_empty), .full(a_full),
    .ent_valid(a_ent_valid), .ent_addr(a_ent_addr)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .Clk(Clk), .ResetN(ResetN), .push(b_push), .push_entry(b_push_entry),
    .pop(grant_b), .head(b_head), .empty(b_empty), .full(b_full),
    .ent_valid(b_ent_valid), .ent_addr(b_ent_addr)
  );

  // Arbitrate heads: same register goes oldest-first, otherwise alternate.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!a_empty && !b_empty) begin
      if (a_head.addr == b_head.addr) grant_b = stamp_older(b_head.stamp, a_head.stamp);
      else                            grant_b = !last_b_q;
      grant_a = !grant_b;
    end else begin
      grant_a = !a_empty;
      grant_b = !b_empty;
    end
    last_b_d = (grant_a || grant_b) ? grant_b : last_b_q;
  end

  // Output stage loads the granted head; address/data hold when idle.
  always_comb begin
    reg_write_d      = grant_a || grant_b;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    grant_b_d        = grant_b_q;
    if (grant_b) begin
      write_register_d = b_head.addr;
      write_data_d     = b_head.data;
      grant_b_d        = 1'b1;
    end else if (grant_a) begin
      write_register_d = a_head.addr;
      write_data_d     = a_head.data;
      grant_b_d        = 1'b0;
    end
  end

  // Sequential state; pointer resets as if B went last so A is favoured.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      stamp_q          <= '0;
      last_b_q         <= 1'b1;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      grant_b_q        <= 1'b0;
    end else begin
      stamp_q          <= stamp_d;
      last_b_q         <= last_b_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      grant_b_q        <= grant_b_d;
    end
  end

  // Pending mask: every live FIFO slot plus a write sitting in the output stage.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_valid[i]) mask[a_ent_addr[i]] = 1'b1;
      if (b_ent_valid[i]) mask[b_ent_addr[i]] = 1'b1;
    end
    if (reg_write_q) mask[write_register_q] = 1'b1;
  end

  assign PendingMask   = mask;
  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;
  assign GrantB        = grant_b_q;
endmodule
